// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains a registered-read byte FIFO onto an asynchronous serial
// line (start bit, DATA_BITS payload LSB first, STOP_BITS stop bits).
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_read_en,
  input  logic [FIFO_WIDTH-1:0] i_fifo_data,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS) + 1;
  localparam int STOP_CYC = STOP_BITS * CLKS_PER_BIT;
  localparam int STOP_W   = (STOP_CYC > 1) ? $clog2(STOP_CYC) : 1;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO   = BAUD_W'(0);
  localparam logic [STOP_W-1:0] STOP_RELOAD = STOP_W'(STOP_CYC - 1);
  localparam logic [STOP_W-1:0] STOP_ONE    = STOP_W'(1);
  localparam logic [STOP_W-1:0] STOP_ZERO   = STOP_W'(0);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ZERO    = IDX_W'(0);

  // ST_POP is the cycle carrying the pop strobe; FETCH latches the word a cycle later.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_FETCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t               state_r;
  logic [BAUD_W-1:0]    baud_cnt_r;
  logic [STOP_W-1:0]    stop_cnt_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 tx_r;
  logic                 busy_r;
  logic                 rd_en_r;
  logic                 done_r;

  logic                 pop_ok_s;
  logic [DATA_BITS-1:0] shift_next_s;
  logic                 fifo_unused_s;

  assign pop_ok_s      = i_enable & ~i_fifo_empty;
  assign shift_next_s  = shift_r >> 1;
  assign fifo_unused_s = ^i_fifo_data;

  assign o_tx           = tx_r;
  assign o_busy         = busy_r;
  assign o_fifo_read_en = rd_en_r;
  assign o_frame_done   = done_r;

  // Frame sequencer; every output is a register so the line never glitches.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= BAUD_ZERO;
      stop_cnt_r <= STOP_ZERO;
      bit_idx_r  <= IDX_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (pop_ok_s) begin
            rd_en_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_POP;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_POP: begin
          state_r <= ST_FETCH;
        end
        ST_FETCH: begin
          shift_r    <= i_fifo_data[DATA_BITS-1:0];
          baud_cnt_r <= BAUD_RELOAD;
          tx_r       <= 1'b0;
          state_r    <= ST_START;
        end
        ST_START: begin
          if (baud_cnt_r == BAUD_ZERO) begin
            baud_cnt_r <= BAUD_RELOAD;
            bit_idx_r  <= IDX_ZERO;
            tx_r       <= shift_r[0];
            state_r    <= ST_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r - BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (baud_cnt_r == BAUD_ZERO) begin
            baud_cnt_r <= BAUD_RELOAD;
            shift_r    <= shift_next_s;
            if (bit_idx_r == IDX_LAST) begin
              tx_r       <= 1'b1;
              stop_cnt_r <= STOP_RELOAD;
              state_r    <= ST_STOP;
            end else begin
              bit_idx_r  <= bit_idx_r + IDX_ONE;
              tx_r       <= shift_next_s[0];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - BAUD_ONE;
          end
        end
        ST_STOP: begin
          tx_r <= 1'b1;
          // Pop decision is taken on the last stop cycle so the next strobe follows immediately.
          if (stop_cnt_r == STOP_ZERO) begin
            if (pop_ok_s) begin
              rd_en_r <= 1'b1;
              busy_r  <= 1'b1;
              state_r <= ST_POP;
            end else begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else begin
            stop_cnt_r <= stop_cnt_r - STOP_ONE;
            done_r     <= (stop_cnt_r == STOP_ONE);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
